alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Execution unit that consumes the 4-bit alu_ctrl code produced by the ALU control decoder and performs the operation on two operands.
- Single-cycle codes (logic, add/sub, slt) complete in one cycle.
- Shifts and multiply run iteratively, one step per cycle.
- Valid/ready handshakes on both sides; sits between the decode/register-read stage and writeback/branch logic; zero flag drives beq.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8. Derived shift-amount width SHW = log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE and not in reset
- alu_ctrl  in  4  operation code, sampled on accept
- operand_a  in  WIDTH  first operand, sampled on accept
- operand_b  in  WIDTH  second operand / shift amount, sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- illegal  out  1  alu_ctrl was not a defined code
- busy  out  1  state is EXEC or DONE

Behaviour:
- Reset (synchronous): state=IDLE; out_valid=0, result=0, zero=0, overflow=0, illegal=0, busy=0. in_ready=0 while reset is high.
- Reset mid-operation aborts the operation with no out_valid pulse. Reset wins over any simultaneous handshake.
- Accept: rising edge with in_valid && in_ready. alu_ctrl, operand_a and operand_b are latched internally; later input changes have no effect.
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 SLT (signed a<b -> 1, else 0); 1100 NOR.
  - 0011 SLL by operand_b[SHW-1:0]; 0100 SRL (logical) by the same amount.
  - 1000 MUL, low WIDTH bits of the unsigned product.
  - All other codes: result=0, illegal=1, single-cycle.
- Arithmetic wraps modulo 2^WIDTH.
- overflow for ADD: operands share a sign and the result sign differs. For SUB: operand signs differ and the result sign differs from a.
- States:
  - IDLE: in_ready=1. On accept, single-cycle codes and shifts with amount 0 go to DONE with the result registered at the accept edge. SLL/SRL with amount>0 and MUL go to EXEC.
  - EXEC: shift moves 1 bit per cycle and the counter decrements. MUL does shift-add, 1 operand_b bit per cycle, WIDTH iterations. When the count is exhausted, register result and flags, then go to DONE.
  - DONE: out_valid=1, with result, zero, overflow and illegal held stable. On out_ready go to IDLE. in_ready stays 0 in DONE, including the out_ready cycle, so there is no overlap.
- Latency from accept edge to out_valid high:
  - single-cycle codes: 1 cycle
  - shift by N>0: N+1 cycles
  - MUL: WIDTH+1 cycles
- out_valid falls in the cycle after out_ready is sampled high in DONE.
- Throughput: at most one op in flight. The earliest next accept is 1 cycle after leaving DONE.
- zero, overflow and illegal update only when result updates. During IDLE and EXEC they hold the last completed op's values; out_valid qualifies them.
- out_ready while not in DONE: ignored.
- in_valid while not in IDLE: ignored; the request must be held by the source.

Test Plan:
- Reset then ADD a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept; result=0x80000000, overflow=1, zero=0.
- SUB a=5, b=5 (beq path) -> result=0, zero=1, overflow=0. Then SLT a=0xFFFFFFFF, b=1 -> result=1.
- SLL a=0x1, b=31 -> out_valid exactly 32 cycles after accept; result=0x80000000. SRL a=0x80000000, b=0 -> result unchanged, latency 1.
- MUL a=0x10001, b=0x10001 -> result=0x00020001 at WIDTH+1=33 cycles. in_ready=0 and in_valid ignored throughout.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags stable and in_ready=0. Raise out_ready -> next cycle IDLE and in_ready=1.
- Illegal code 1111 -> illegal=1, result=0, latency 1. Assert reset 10 cycles into a MUL -> no out_valid, all outputs 0, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_iterative_if.sv
// Purpose: request/response bundle between the issue stage and the iterative ALU.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports (slave = ALU side):
//   in_valid, alu_ctrl, operand_a, operand_b, out_ready        -> into the ALU
//   in_ready, out_valid, result, zero, overflow, illegal, busy -> out of the ALU
interface alu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, alu_ctrl, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal, busy
    );

    modport slave (
        input  in_valid, alu_ctrl, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal, busy
    );
endinterface

// File: rtl/alu_iterative.sv
// Purpose: ALU executing alu_ctrl codes; logic/add/sub/slt in one step, shifts and multiply iteratively.
// Latency: 1 cycle single-step codes, N+1 for shift by N>0, WIDTH+1 for MUL (accept edge to out_valid).
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready low outside IDLE.
// Ports: clk, reset (synchronous, active-high); bus = alu_iterative_if.slave carrying the
//        request handshake (in_valid/in_ready, alu_ctrl, operand_a, operand_b) and the
//        result handshake (out_valid/out_ready, result, zero, overflow, illegal, busy).
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_iterative_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // Counter is one bit wider than a shift amount so it can hold WIDTH for MUL.
    localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] sh_dat;   // shift operand, or left-shifting multiplicand for MUL
    logic [WIDTH-1:0] mul_b;    // multiplier, consumed LSB first
    logic [WIDTH-1:0] acc;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic             illegal_q;

    logic             accept;
    logic [SHW-1:0]   amt;

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign amt    = bus.operand_b[SHW-1:0];

    // Single-step result, evaluated directly on the request inputs so it can be
    // registered on the accept edge.
    logic [WIDTH-1:0] op_a, op_b, sum, diff, sc_res;
    logic             sc_ovf, sc_ill, go_exec;

    always_comb begin
        op_a    = bus.operand_a;
        op_b    = bus.operand_b;
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_ill  = 1'b0;
        go_exec = 1'b0;
        case (bus.alu_ctrl)
            OP_AND: sc_res = op_a & op_b;
            OP_OR:  sc_res = op_a | op_b;
            OP_NOR: sc_res = ~(op_a | op_b);
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL, OP_SRL: begin
                // A zero-amount shift is just a pass-through and finishes immediately.
                sc_res  = op_a;
                go_exec = (amt != '0);
            end
            OP_MUL: go_exec = 1'b1;
            default: sc_ill = 1'b1;
        endcase
    end

    // One iteration step. SLL and MUL both shift sh_dat left, so they share it.
    logic [WIDTH-1:0] sh_next, acc_next, exec_res;

    always_comb begin
        sh_next  = (op == OP_SRL) ? (sh_dat >> 1) : (sh_dat << 1);
        acc_next = mul_b[0] ? (acc + sh_dat) : acc;
        exec_res = (op == OP_MUL) ? acc_next : sh_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op         <= '0;
            sh_dat     <= '0;
            mul_b      <= '0;
            acc        <= '0;
            cnt        <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op     <= bus.alu_ctrl;
                        sh_dat <= bus.operand_a;
                        mul_b  <= bus.operand_b;
                        acc    <= '0;
                        cnt    <= (bus.alu_ctrl == OP_MUL) ? MUL_CNT : {1'b0, amt};
                        if (go_exec) begin
                            state <= EXEC;
                        end else begin
                            result_q   <= sc_res;
                            zero_q     <= (sc_res == '0);
                            overflow_q <= sc_ovf;
                            illegal_q  <= sc_ill;
                            state      <= DONE;
                        end
                    end
                end
                EXEC: begin
                    sh_dat <= sh_next;
                    mul_b  <= mul_b >> 1;
                    acc    <= acc_next;
                    cnt    <= cnt - CNT_ONE;
                    // Last step: take the combinational next value straight into the result.
                    if (cnt == CNT_ONE) begin
                        result_q   <= exec_res;
                        zero_q     <= (exec_res == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iterative.sv
// Purpose: self-checking bench for alu_iterative, directed cases plus random ops against a reference model.
// Latency: measured from accept edge to first cycle out_valid is seen high.
// Backpressure: exercises held out_ready, in_valid while busy, and reset mid-MUL.
module tb_alu_iterative;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_iterative_if #(.WIDTH(W)) bus ();

    alu_iterative #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the operation written as plain arithmetic on the code's meaning.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic ov, output logic il, output int lat);
        longint s;
        int     amt;
        amt = int'(b[4:0]);
        ov  = 1'b0;
        il  = 1'b0;
        lat = 1;
        r   = '0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd12: r = ~(a | b);
            4'd2: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                r  = a + b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                r  = a - b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: begin r = a << amt; lat = amt + 1; end
            4'd4: begin r = a >> amt; lat = amt + 1; end
            4'd8: begin r = W'(64'(a) * 64'(b)); lat = W + 1; end
            default: il = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic         eo, ei;
        int           elat, cyc;
        model(op, a, b, er, eo, ei, elat);
        cyc = 0;
        @(negedge clk);
        while (!bus.in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1;
        // Keep requesting garbage while busy; it must not be taken or disturb the op.
        bus.alu_ctrl  = 4'($urandom_range(0, 15));
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        @(negedge clk);
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) check({tag, "_inrdy_busy"}, 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_lat"}, 64'(cyc), 64'(elat));
        check({tag, "_res"}, 64'(bus.result), 64'(er));
        check({tag, "_zero"}, 64'(bus.zero), 64'(er == '0));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
        check({tag, "_ill"}, 64'(bus.illegal), 64'(ei));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_res"}, 64'(bus.result), 64'(er));
            check({tag, "_hold_flags"}, {61'd0, bus.zero, bus.overflow, bus.illegal},
                  {61'd0, (er == '0), eo, ei});
            check({tag, "_hold_inrdy"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drop_vld"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_idle_inrdy"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inrdy", 64'(bus.in_ready), 64'd0);
        check("rst_vld", 64'(bus.out_valid), 64'd0);
        check("rst_outs", {59'd0, bus.busy, bus.zero, bus.overflow, bus.illegal, (bus.result != '0)}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_inrdy", 64'(bus.in_ready), 64'd1);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
        run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sll_31", 4'b0011, 32'h1, 32'd31, 0);
        run_op("srl_0", 4'b0100, 32'h8000_0000, 32'd0, 0);
        run_op("mul", 4'b1000, 32'h0001_0001, 32'h0001_0001, 0);
        run_op("bp_and", 4'b0000, 32'hF0F0_1234, 32'hFF00_FF0F, 5);
        run_op("illegal", 4'b1111, 32'h1234, 32'h5678, 0);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 0);

        // Reset ten cycles into a multiply: no result may appear.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.alu_ctrl  = 4'b1000;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mul_pre_rst_vld", 64'(bus.out_valid), 64'd0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_inrdy", 64'(bus.in_ready), 64'd0);
        check("midrst_outs", {58'd0, bus.out_valid, bus.busy, bus.zero, bus.overflow, bus.illegal,
              (bus.result != '0)}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_after_inrdy", 64'(bus.in_ready), 64'd1);
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) check("midrst_no_vld", 64'(bus.out_valid), 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (n % 5 == 0) b = b & 32'h1F;
            if (n % 7 == 0) a = b;
            run_op("rand", op, a, b, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
